// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: datapath width, arctan ROM (degrees, Q8.12) and the
// sequencer state encoding.
package cordic_pkg;

  localparam int CORDIC_W = 20;
  localparam int LUT_N    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } cordic_state_e;

  // round(atan(2^-k) [deg] * 4096)
  localparam logic [CORDIC_W-1:0] ATAN_LUT [LUT_N] = '{
    20'd184320, 20'd108810, 20'd57492, 20'd29184,
    20'd14649,  20'd7331,   20'd3667,  20'd1833,
    20'd917,    20'd458,    20'd229,   20'd115,
    20'd57,     20'd29,     20'd14,    20'd7
  };

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// Request/result handshake bundle between a CORDIC client and the sequencer.
interface cordic_seq_ctrl_if
  import cordic_pkg::*;
#(
  parameter int W = CORDIC_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [W-1:0] target_angle;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic [W-1:0] angle_out;
  logic         busy;

  modport master (
    output in_valid, x_in, y_in, target_angle, out_ready,
    input  in_ready, out_valid, x_out, y_out, angle_out, busy
  );

  modport slave (
    input  in_valid, x_in, y_in, target_angle, out_ready,
    output in_ready, out_valid, x_out, y_out, angle_out, busy
  );
endinterface

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation; all arithmetic wraps modulo 2^W.
module cordic_stage #(
  parameter int W = 20
) (
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] ang_in,
  input  logic [W-1:0] atan,
  input  logic [3:0]   shift,
  input  logic         add,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] ang_out
);
  logic signed [W-1:0] xs, ys;

  assign xs = $signed(x_in) >>> shift;
  assign ys = $signed(y_in) >>> shift;

  // add: rotate counter-clockwise and advance the angle accumulator
  assign x_out   = add ? x_in - ys      : x_in + ys;
  assign y_out   = add ? y_in + xs      : y_in - xs;
  assign ang_out = add ? ang_in + atan  : ang_in - atan;
endmodule

// File: rtl/cordic_seq_ctrl.sv
// Iterative CORDIC rotation sequencer: one micro-rotation per clock through a
// single shared stage, N_ITER iterations per request.
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int N_ITER = 16,
  parameter int W      = CORDIC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  cordic_seq_ctrl_if.slave  bus
);
  localparam logic [3:0] LAST_I = 4'(N_ITER - 1);

  cordic_state_e state_q, state_d;

  logic [3:0]          iter_q;
  logic [W-1:0]        x_q, y_q, ang_q, tgt_q;
  logic [W-1:0]        x_nxt, y_nxt, ang_nxt, atan_k;
  logic signed [W-1:0] diff;
  logic                add, last;

  assign last   = (iter_q == LAST_I);
  assign atan_k = W'(ATAN_LUT[iter_q]);

  // Direction from the wrapped difference so targets near 0 still converge
  // when the accumulator dips below zero.
  assign diff = tgt_q - ang_q;
  assign add  = (diff >= 0);

  cordic_stage #(.W(W)) u_stage (
    .x_in   (x_q),
    .y_in   (y_q),
    .ang_in (ang_q),
    .atan   (atan_k),
    .shift  (iter_q),
    .add    (add),
    .x_out  (x_nxt),
    .y_out  (y_nxt),
    .ang_out(ang_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_d = ITER;
      end
      ITER: if (last) state_d = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      ang_q  <= '0;
      tgt_q  <= '0;
    end else if (clr) begin
      iter_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      ang_q  <= '0;
      tgt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          iter_q <= '0;
          x_q    <= bus.x_in;
          y_q    <= bus.y_in;
          ang_q  <= '0;
          tgt_q  <= bus.target_angle;
        end
        ITER: begin
          x_q    <= x_nxt;
          y_q    <= y_nxt;
          ang_q  <= ang_nxt;
          iter_q <= iter_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.angle_out = ang_q;
endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl with hand-computed expectations.
module tb_cordic_seq_ctrl;
  import cordic_pkg::*;
  localparam int W = CORDIC_W;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  cordic_seq_ctrl_if #(.W(W)) bus ();

  cordic_seq_ctrl #(.N_ITER(16), .W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Difference taken modulo 2^W so wrapped results compare naturally.
  task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
    logic signed [W-1:0] d;
    checks++;
    d = W'(obs - exp);
    if (int'(d) > tol || int'(d) < -tol) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int x, input int y, input int t);
    bus.in_valid     = 1'b1;
    bus.x_in         = W'(x);
    bus.y_in         = W'(y);
    bus.target_angle = W'(t);
    step();
    bus.in_valid     = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat, seen, n, idle;
    int xs, ys, as;
    int acc_cyc [8];

    bus.in_valid     = 1'b0;
    bus.x_in         = '0;
    bus.y_in         = '0;
    bus.target_angle = '0;
    bus.out_ready    = 1'b0;
    clr              = 1'b0;
    rst_n            = 1'b0;

    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_x", bus.x_out, 0);
    chk("rst_ang", bus.angle_out, 0);
    rst_n = 1'b1;
    step();

    // 0 degrees: early iterations checked exactly, final result by tolerance
    issue(39797, 0, 0);
    chk("a_busy", bus.busy, 1);
    chk("a_in_ready", bus.in_ready, 0);
    chk("a_x0", bus.x_out, 39797);
    step();
    chk("a_x1", bus.x_out, 39797);
    chk("a_y1", bus.y_out, 39797);
    chk("a_ang1", bus.angle_out, 184320);
    step();
    chk("a_x2", bus.x_out, 59695);
    chk("a_y2", bus.y_out, 19899);
    chk("a_ang2", bus.angle_out, 75510);
    wait_done(lat);
    chk("a_latency", lat + 2, 16);
    chk("a_x", bus.x_out, 65536, 16);
    chk("a_y", bus.y_out, 0, 16);
    chk("a_ang", bus.angle_out, 0, 4);
    chk("a_done_rdy", bus.in_ready, 0);
    drain();
    chk("a_post_valid", bus.out_valid, 0);
    chk("a_post_rdy", bus.in_ready, 1);

    // 45 degrees, then stall the result for 10 cycles with in_valid asserted
    issue(39797, 0, 184320);
    wait_done(lat);
    chk("b_latency", lat, 16);
    chk("b_x", bus.x_out, 46341, 16);
    chk("b_y", bus.y_out, 46341, 16);
    chk("b_ang", bus.angle_out, 184320, 4);
    xs = int'(bus.x_out);
    ys = int'(bus.y_out);
    as = int'(bus.angle_out);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("st_valid", bus.out_valid, 1);
      chk("st_rdy", bus.in_ready, 0);
    end
    chk("st_x", bus.x_out, xs);
    chk("st_y", bus.y_out, ys);
    chk("st_ang", bus.angle_out, as);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("rel_idle", bus.in_ready, 1);
    chk("rel_valid", bus.out_valid, 0);
    step();
    bus.in_valid = 1'b0;
    chk("rel_accept", bus.busy, 1);

    // clr at i=7 aborts; a following request completes normally
    clr = 1'b1;
    step();
    clr = 1'b0;
    issue(39797, 0, 0);
    repeat (7) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_rdy", bus.in_ready, 1);
    chk("clr_busy", bus.busy, 0);
    chk("clr_x", bus.x_out, 0);
    chk("clr_ang", bus.angle_out, 0);
    seen = 0;
    repeat (20) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("clr_no_valid", seen, 0);
    issue(39797, 0, 0);
    wait_done(lat);
    chk("clr_next_lat", lat, 16);
    chk("clr_next_x", bus.x_out, 65536, 16);
    drain();

    // Wrap: 524287 + 524287 = 1048574 (mod 2^20), x cancels to 0
    issue(524287, 524287, 0);
    step();
    chk("w_x1", bus.x_out, 0);
    chk("w_y1", bus.y_out, 1048574);
    chk("w_ang1", bus.angle_out, 184320);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Asynchronous reset mid-ITER, observed before the next edge
    issue(39797, 0, 184320);
    repeat (5) step();
    #3 rst_n = 1'b0;
    #1;
    chk("ar_rdy", bus.in_ready, 1);
    chk("ar_busy", bus.busy, 0);
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_x", bus.x_out, 0);
    chk("ar_y", bus.y_out, 0);
    chk("ar_ang", bus.angle_out, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("ar_no_valid", seen, 0);

    // in_valid and out_ready held high: one accept every 18 cycles
    bus.x_in         = W'(39797);
    bus.y_in         = '0;
    bus.target_angle = '0;
    bus.in_valid     = 1'b1;
    bus.out_ready    = 1'b1;
    n    = 0;
    idle = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.in_ready && n < 8) begin
        acc_cyc[n] = c;
        n++;
      end
      if (!bus.busy) idle++;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("cont_accepts", n, 4);
    chk("cont_gap1", acc_cyc[1] - acc_cyc[0], 18);
    chk("cont_gap2", acc_cyc[2] - acc_cyc[1], 18);
    chk("cont_gap3", acc_cyc[3] - acc_cyc[2], 18);
    chk("cont_idle", idle, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_seq_ctrl.md
CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

Interface
REQ-001 SHALL have parameter N_ITER, default 16, number of CORDIC micro-rotations per operation (1..16).
REQ-002 SHALL have parameter W, default 20, datapath width of x, y and angle.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clr, input, 1, synchronous abort of any operation in progress.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the operation-request handshake.
REQ-007 SHALL have ports x_in and y_in, input, W each, two's-complement start vector.
REQ-008 SHALL have port target_angle, input, W, unsigned Q8.12 degrees (LSB = 1/4096 degree).
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-010 SHALL have ports x_out and y_out, output, W each, rotated vector, two's complement.
REQ-011 SHALL have port angle_out, output, W, accumulated angle, Q8.12.
REQ-012 SHALL have port busy, output, 1, high in every state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ITER and DONE.
REQ-014 SHALL drive in_ready high only in IDLE.
REQ-015 SHALL, on an edge with in_valid & in_ready, capture x_in, y_in and target_angle, clear the angle accumulator to 0, clear iteration counter i to 0 and enter ITER.
REQ-016 SHALL, on each ITER edge, load the stage results into the x, y and angle registers and increment i.
REQ-017 SHALL compute each stage result with shift i and arctan constant ATAN_LUT[i].
REQ-018 SHALL select the rotation direction by comparing the captured target angle with the accumulator: target >= accumulator adds, otherwise subtracts.
REQ-019 SHALL enter DONE on the ITER edge where i == N_ITER-1, so out_valid rises exactly N_ITER edges after the accept edge.
REQ-020 SHALL hold x_out, y_out, angle_out and out_valid stable in DONE until an edge with out_ready high, then return to IDLE.
REQ-021 SHALL NOT accept a new request in the DONE cycle in which out_ready is high, because in_ready is low there; the minimum request spacing is N_ITER+2 cycles.
REQ-022 SHALL wrap all x/y/angle arithmetic modulo 2^W without saturation.
REQ-023 SHALL, when clr is high, enter IDLE on the next edge with out_valid low and registers cleared; clr takes priority over in_valid and out_ready.
REQ-024 SHALL ignore in_valid while busy, and SHALL ignore out_ready outside DONE.
REQ-025 SHALL drive x_out, y_out and angle_out from the working registers at all times; they are meaningful only while out_valid is high.

Reset
REQ-026 SHALL, while rst_n is low, immediately force state IDLE, i=0, x/y/angle registers to 0, out_valid=0 and busy=0, with in_ready=1 after reset.
REQ-027 SHALL abandon any operation in progress when rst_n asserts mid-operation, with no result produced.

Structure
REQ-028 SHALL place ATAN_LUT in a shared package cordic_pkg: 16 entries, round(atan(2^-k)*4096), e.g. [0]=184320 and [1]=108810.
REQ-029 SHALL place the CORDIC_W=20 constant and the state enum in cordic_pkg.
REQ-030 SHALL instantiate exactly one existing cordic_stage as its datapath sub-module.
REQ-031 SHALL keep the sequencing, ROM indexing and registers in this module, with the sub-module purely combinational.

Verification
REQ-032 SHALL cover: x_in=39797, y_in=0, target=0 -> out_valid 16 cycles after accept; x_out within 65536±16; |y_out|<=16; angle_out within 0±4.
REQ-033 SHALL cover: x_in=39797, y_in=0, target=184320 (45 degrees) -> x_out and y_out both within 46341±16; angle_out within 184320±4.
REQ-034 SHALL cover: out_ready held low for 10 cycles after out_valid -> outputs stable, in_ready low throughout, accept possible 2 cycles after out_ready.
REQ-035 SHALL cover: clr pulsed at ITER i=7 -> IDLE next cycle, out_valid never rises, a following request completes normally.
REQ-036 SHALL cover: rst_n low mid-ITER asynchronously -> all outputs 0 and in_ready=1 before the next clock edge.
REQ-037 SHALL cover: in_valid held high continuously -> exactly one accept per N_ITER+2 cycles and busy never drops during ITER.
